// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, DATA_BITS data bits LSB-first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit and a parity_err output.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int TCW        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [TCW-1:0] TICK_MID = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TICK_END = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               state, state_nxt;
  logic [TCW-1:0]       tick_cnt, tick_nxt;
  logic [BCW-1:0]       bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt;
  logic                 rx_p0, rx_p1, rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nxt, perr_nxt;
`endif

  assign rx_s = rx_p1;

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
    perr_nxt  = 1'b0;
`endif
    if (baud) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            // Start bit must still be low at its midpoint, otherwise it was a glitch
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_END) begin
            shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
            bit_nxt   = bit_cnt + 1'b1;
            tick_nxt  = '0;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == TICK_END) begin
            par_nxt   = rx_s;
            tick_nxt  = '0;
            state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt == TICK_END) begin
            tick_nxt = '0;
            if (rx_s) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_nxt  = (^shift) ^ par_bit;
`endif
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        BREAK: begin
          // A line held low must go high before another frame can start
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0       <= 1'b1;
      rx_p1       <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_p0       <= rx;
      rx_p1       <= rx_p0;
      state       <= state_nxt;
      tick_cnt    <= tick_nxt;
      bit_cnt     <= bit_nxt;
      shift       <= shift_nxt;
      data        <= data_nxt;
      valid       <= valid_nxt;
      framing_err <= ferr_nxt;
      busy        <= (state != IDLE);
`ifdef UART_RX_PARITY_EN
      par_bit     <= par_nxt;
      parity_err  <= perr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: baud tick every 4 clk (64 clk per bit), table vectors, corner sequences, random frames.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst, baud, rx;
  logic [7:0] data;
  logic       valid, framing_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0, bad = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .TCW(4)) dut (
    .clk(clk), .rst(rst), .baud(baud), .rx(rx),
    .data(data), .valid(valid), .framing_err(framing_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #10 clk = ~clk;

  initial begin
    baud = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pulse monitor
  always @(negedge clk) begin
    if (valid || framing_err) check("valid_ferr_exclusive", {31'd0, valid & framing_err}, 32'd0);
    if (valid) begin
      n_valid++;
      check("busy_in_valid_cycle", {31'd0, busy}, 32'd1);
    end
    if (framing_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
    if (prev_valid) check("busy_after_valid", {31'd0, busy}, 32'd0);
    prev_valid = valid;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^v) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity build");
`endif
    send_bit(stop);
  endtask

  // Reference rule: a high stop bit delivers the byte; a low one flags a framing error and keeps data.
  task automatic run_frame(input string tag, input logic [7:0] v, input logic stop, input int gap);
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(v, stop, 1'b0);
    if (stop) exp_data = v;
    check({tag, " valid_count"}, n_valid - v0, stop ? 1 : 0);
    check({tag, " ferr_count"}, n_ferr - f0, stop ? 0 : 1);
    check({tag, " data"}, {24'd0, data}, {24'd0, exp_data});
    for (int g = 0; g < gap; g++) send_bit(1'b1);
  endtask

  typedef struct {
    logic [7:0] v;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0, p0;
    logic [7:0] rv;
    logic       rs;
    int         rg;

    vecs[0] = '{8'hA5, 1'b1, 1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
    vecs[3] = '{8'h5A, 1'b0, 1, 0, 1, 8'hFF};
    vecs[4] = '{8'h01, 1'b1, 0, 1, 0, 8'h01};
    vecs[5] = '{8'h80, 1'b1, 1, 1, 0, 8'h80};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    check("reset data", {24'd0, data}, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset ferr", {31'd0, framing_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (BIT_CLK) @(negedge clk);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(vecs[i].v, vecs[i].stop, 1'b0);
      check($sformatf("vec%0d valid_count", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d ferr_count", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d data", i), {24'd0, data}, {24'd0, vecs[i].exp_data});
      for (int g = 0; g < vecs[i].gap; g++) send_bit(1'b1);
    end
    exp_data = 8'h80;

    // Glitch on the start bit
    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch busy_high", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check("glitch busy_low", {31'd0, busy}, 32'd0);
    repeat (BIT_CLK * 2) @(negedge clk);
    check("glitch valid_count", n_valid - v0, 0);
    check("glitch ferr_count", n_ferr - f0, 0);

    // Framing error followed by a held-low line
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (3 * BIT_CLK) @(negedge clk);
    check("break busy_held", {31'd0, busy}, 32'd1);
    check("break ferr_count", n_ferr - f0, 1);
    check("break valid_count", n_valid - v0, 0);
    check("break data_kept", {24'd0, data}, {24'd0, exp_data});
    send_bit(1'b1);
    check("break busy_released", {31'd0, busy}, 32'd0);
    check("break no_new_pulses", (n_valid - v0) + (n_ferr - f0), 1);

    // Reset during data bit 4 of 0x55
    v0 = n_valid;
    f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rv_bit(8'h55, i));
    rx = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst data", {24'd0, data}, 32'd0);
    check("midrst valid", {31'd0, valid}, 32'd0);
    check("midrst ferr", {31'd0, framing_err}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    exp_data = 8'h00;
    repeat (BIT_CLK * 12) @(negedge clk);
    check("midrst no_pulse", (n_valid - v0) + (n_ferr - f0), 0);
    run_frame("after_rst", 8'h81, 1'b1, 1);

`ifdef UART_RX_PARITY_EN
    p0 = n_perr;
    v0 = n_valid;
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1);
    check("parity_good perr", n_perr - p0, 0);
    check("parity_good valid", n_valid - v0, 1);
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    check("parity_bad perr", n_perr - p0, 1);
    check("parity_bad valid", n_valid - v0, 2);
    check("parity_bad data", {24'd0, data}, 32'h07);
    exp_data = 8'h07;
`else
    p0 = n_perr;
    check("no_parity perr", n_perr - p0, 0);
`endif

    // Random frames against the reference rule
    for (int k = 0; k < 10; k++) begin
      rv = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rg = rs ? int'($urandom_range(0, 1)) : 1;
      run_frame($sformatf("rand%0d", k), rv, rs, rg);
    end

    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic rv_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
